// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file with scoreboard.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NWPORT   = 2;
    localparam int WP_ALU   = 0;
    localparam int WP_LD    = 1;

    // Low bit of element idx inside a packed multi-port bus of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_busy_tracker.sv
// Per-register busy bits, issue acceptance and a running count of busy registers.
module rf_busy_tracker
    import rf_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_rd,
    input  logic [NWPORT-1:0]    i_wen,
    input  logic [NWPORT*AW-1:0] i_waddr,
    output logic                 o_iss_ready,
    output logic [NREG-1:0]      o_busy,
    output logic [AW:0]          o_pending
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     pending_q, pending_d;
    logic [AW-1:0]   wa_alu, wa_ld;
    logic            rd_is_zero, iss_set, clr_alu, clr_ld;

    assign wa_alu = i_waddr[slice_lo(WP_ALU, AW) +: AW];
    assign wa_ld  = i_waddr[slice_lo(WP_LD, AW) +: AW];

    assign rd_is_zero  = ZERO_REG && (i_iss_rd == '0);
    assign o_iss_ready = rd_is_zero || !busy_q[i_iss_rd];
    assign iss_set     = i_iss_valid && o_iss_ready && !rd_is_zero;

    // A clear counts only when it drops a set bit that the issue does not re-set,
    // and two ports hitting one register drop it once.
    assign clr_alu = i_wen[WP_ALU] && busy_q[wa_alu] && !(iss_set && (wa_alu == i_iss_rd));
    assign clr_ld  = i_wen[WP_LD] && busy_q[wa_ld] && !(iss_set && (wa_ld == i_iss_rd))
                     && !(i_wen[WP_ALU] && (wa_ld == wa_alu));

    always_comb begin
        busy_d = busy_q;
        if (i_wen[WP_ALU]) busy_d[wa_alu] = 1'b0;
        if (i_wen[WP_LD])  busy_d[wa_ld]  = 1'b0;
        if (iss_set)       busy_d[i_iss_rd] = 1'b1;
        pending_d = pending_q + (AW+1)'(iss_set) - (AW+1)'(clr_alu) - (AW+1)'(clr_ld);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_pending = pending_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-read, dual-write register file with a busy-bit scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRPORT   = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NRPORT*AW-1:0]   i_raddr,
    output logic [NRPORT*XLEN-1:0] o_rdata,
    output logic [NRPORT-1:0]      o_rbusy,
    input  logic                   i_iss_valid,
    input  logic [AW-1:0]          i_iss_rd,
    output logic                   o_iss_ready,
    input  logic [NWPORT-1:0]      i_wen,
    input  logic [NWPORT*AW-1:0]   i_waddr,
    input  logic [NWPORT*XLEN-1:0] i_wdata,
    output logic [AW:0]            o_pending
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [AW-1:0]   wa [NWPORT];
    logic [XLEN-1:0] wd [NWPORT];
    logic            wv [NWPORT];
    logic [AW-1:0]   ra [NRPORT];
    logic [NREG-1:0] busy;

    rf_busy_tracker #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .i_wen       (i_wen),
        .i_waddr     (i_waddr),
        .o_iss_ready (o_iss_ready),
        .o_busy      (busy),
        .o_pending   (o_pending)
    );

    // wv is the write that really lands; writes to a hardwired zero register vanish.
    always_comb begin
        for (int p = 0; p < NWPORT; p++) begin
            wa[p] = i_waddr[slice_lo(p, AW) +: AW];
            wd[p] = i_wdata[slice_lo(p, XLEN) +: XLEN];
            wv[p] = i_wen[p] && !(ZERO_REG && (wa[p] == '0));
        end
    end

    // Ports are applied in ascending order so the load port overrides the ALU port.
    always_comb begin
        for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
        for (int p = 0; p < NWPORT; p++) begin
            if (wv[p]) regs_d[wa[p]] = wd[p];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
        end
    end

    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        for (int k = 0; k < NRPORT; k++) begin
            ra[k] = i_raddr[slice_lo(k, AW) +: AW];
            if (!(ZERO_REG && (ra[k] == '0))) begin
                o_rdata[slice_lo(k, XLEN) +: XLEN] = regs_q[ra[k]];
                o_rbusy[k] = busy[ra[k]];
`ifdef RF_BYPASS_EN
                for (int p = 0; p < NWPORT; p++) begin
                    if (wv[p] && (wa[p] == ra[k])) begin
                        o_rdata[slice_lo(k, XLEN) +: XLEN] = wd[p];
                        o_rbusy[k] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: driver pushes expectations, a negedge monitor checks them.
module tb_rf_scoreboard;

  localparam int AW = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [3:0] K_RD0 = 4'd0, K_RD1 = 4'd1, K_BUSY = 4'd2, K_RDY = 4'd3, K_PEND = 4'd4;
  localparam int WATCHDOG_CYCLES = 20000;

  logic            clk, rst_n;
  logic [2*AW-1:0] raddr;
  logic [63:0]     rdata;
  logic [1:0]      rbusy;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic [1:0]      wen;
  logic [2*AW-1:0] waddr;
  logic [63:0]     wdata;
  logic [AW:0]     pending;

  logic [35:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  rf_scoreboard dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_raddr     (raddr),
    .o_rdata     (rdata),
    .o_rbusy     (rbusy),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_wen       (wen),
    .i_waddr     (waddr),
    .i_wdata     (wdata),
    .o_pending   (pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    wen       = 2'b00;
    iss_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
    wen[port] = 1'b1;
    if (port == 0) begin
      waddr[AW-1:0] = a;
      wdata[31:0]   = d;
    end else begin
      waddr[2*AW-1:AW] = a;
      wdata[63:32]     = d;
    end
  endtask

  task automatic iss(input logic [AW-1:0] r);
    iss_valid = 1'b1;
    iss_rd    = r;
  endtask

  task automatic chk(input logic [3:0] kind, input logic [31:0] val);
    exp_q.push_back({kind, val});
  endtask

  task automatic chk_reset_state();
    n_tests++;
    if ((iss_ready !== 1'b1) || (pending !== '0) || (rbusy !== 2'b00)) begin
      n_fail++;
      $display("FAIL reset state @%0t: iss_ready=%b pending=%0d rbusy=%b",
               $time, iss_ready, pending, rbusy);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [35:0] e;
    logic [31:0] act;
    string nm;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e[35:32])
        K_RD0:   begin act = rdata[31:0];        nm = "rdata0";    end
        K_RD1:   begin act = rdata[63:32];       nm = "rdata1";    end
        K_BUSY:  begin act = {30'b0, rbusy};     nm = "rbusy";     end
        K_RDY:   begin act = {31'b0, iss_ready}; nm = "iss_ready"; end
        default: begin act = {26'b0, pending};   nm = "pending";   end
      endcase
      n_tests++;
      if (act !== e[31:0]) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, e[31:0]);
      end
    end
  end

  // watchdog
  initial begin
    repeat (WATCHDOG_CYCLES) @(posedge clk);
    if (!done) begin
      n_fail++;
      $display("FAIL watchdog expired after %0d cycles", WATCHDOG_CYCLES);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    raddr  = '0;
    waddr  = '0;
    wdata  = '0;
    iss_rd = '0;
    #1;
    chk_reset_state();
    iss(5);
    chk(K_RDY, 1); chk(K_PEND, 0); chk(K_BUSY, 0); chk(K_RD0, 0);
    step();
    step();
    chk_reset_state();
    rst_n = 1'b1;

    // every register reads zero after reset
    for (int a = 0; a < 32; a++) begin
      step();
      rd(AW'(a), AW'(31 - a));
      chk(K_RD0, 0); chk(K_RD1, 0); chk(K_BUSY, 0);
    end
    iss_rd = 5'd31;
    chk(K_PEND, 0); chk(K_RDY, 1);

    // plain writes to idle registers leave the count at zero
    step(); wr(0, 1, 32'h11); wr(1, 2, 32'h22);
    step(); rd(1, 2);
    chk(K_RD0, 32'h11); chk(K_RD1, 32'h22); chk(K_PEND, 0);

    // double issue to one register stalls
    step(); iss(5); chk(K_RDY, 1); chk(K_PEND, 0);
    step(); iss(5); rd(0, 5);
    chk(K_RDY, 0); chk(K_PEND, 1); chk(K_BUSY, 2'b10);
    step(); rd(5, 0);
    chk(K_PEND, 1); chk(K_BUSY, 2'b01);

    // both write ports to reg 5: load port wins, busy clears once
    step(); wr(0, 5, 32'hDEADBEEF); wr(1, 5, 32'h12345678); rd(5, 5);
    chk(K_RD0, BYP ? 32'h12345678 : 32'h0);
    chk(K_BUSY, BYP ? 32'h0 : 32'h3);
    chk(K_PEND, 1);
    step(); rd(5, 1);
    chk(K_RD0, 32'h12345678); chk(K_RD1, 32'h11); chk(K_BUSY, 0); chk(K_PEND, 0);

    // issue and write to reg 7 in the same cycle: set wins, data lands
    step(); iss(7); wr(0, 7, 32'hA5); chk(K_RDY, 1);
    step(); rd(7, 0);
    chk(K_RD0, 32'hA5); chk(K_BUSY, 2'b01); chk(K_PEND, 1);
    step(); wr(1, 7, 32'h77);
    step(); rd(7, 0);
    chk(K_RD0, 32'h77); chk(K_BUSY, 0); chk(K_PEND, 0);

    // two different busy registers cleared in one cycle
    step(); iss(4);
    step(); iss(6); chk(K_PEND, 1);
    step(); wr(0, 4, 32'h44); wr(1, 6, 32'h66); rd(4, 6);
    chk(K_PEND, 2);
    chk(K_BUSY, BYP ? 32'h0 : 32'h3);
    chk(K_RD0, BYP ? 32'h44 : 32'h0);
    step(); rd(4, 6);
    chk(K_RD0, 32'h44); chk(K_RD1, 32'h66); chk(K_PEND, 0);

    // register 0 ignores writes and issues
    step(); wr(0, 0, 32'hFFFF); iss(0); rd(0, 0);
    chk(K_RDY, 1); chk(K_RD0, 0);
    step(); rd(0, 0); iss_rd = 5'd0;
    chk(K_RD0, 0); chk(K_RD1, 0); chk(K_PEND, 0); chk(K_BUSY, 0); chk(K_RDY, 1);

    // same-cycle write vs read of reg 3
    step(); iss(3);
    step(); wr(0, 3, 32'h55); rd(3, 2);
    chk(K_RD0, BYP ? 32'h55 : 32'h0);
    chk(K_RD1, 32'h22);
    chk(K_BUSY, BYP ? 32'h0 : 32'h1);
    step(); rd(3, 3);
    chk(K_RD0, 32'h55); chk(K_RD1, 32'h55); chk(K_BUSY, 0); chk(K_PEND, 0);

    // reset in the middle of activity drops everything
    step(); iss(9);
    step(); wr(0, 11, 32'hBB); iss(12); rd(1, 9);
    rst_n = 1'b0;
    chk(K_PEND, 0); chk(K_RDY, 1); chk(K_RD0, 0); chk(K_BUSY, 0);
    step(); rst_n = 1'b1; rd(11, 2); iss_rd = 5'd9;
    chk(K_RD0, 0); chk(K_RD1, 0); chk(K_BUSY, 0); chk(K_PEND, 0); chk(K_RDY, 1);

    step();
    step();
    @(negedge clk);
    #1;
    done = 1'b1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %0d expectations never checked", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
